step_input: RTL

Input-side front end for the board-level CPU wrapper: takes the raw, bouncing step push-button and the raw 2-bit display-type switches and turns them into clean signals in the `base_clk` domain. It produces a single-cycle `step` pulse per debounced press. It also provides a synchronized `type` bus and a wrapping step counter. `step` replaces the raw button as the CPU single-step advance; `type` feeds the 7-segment display mux.

---
 rtl/step_input.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/step_input.sv
`default_nettype none
// ============================================================================
//  Module   : step_input
//  Purpose  : Board-level input front end for the CPU wrapper. Synchronizes
//             and debounces the raw step push-button into a single-cycle
//             'step' pulse per accepted press. Also synchronizes the 2-bit
//             display-type switches and keeps a wrapping count of step pulses.
//  Ports    : base_clk   in   sole clock, rising edge
//             reset      in   synchronous, active-low reset
//             btn_raw    in   raw step button (async, active-high, bouncing)
//             type_raw   in   raw display-type switches (async)
//             step       out  one-cycle pulse per accepted press / repeat
//             btn_level  out  debounced button level
//             type_sync  out  type_raw after a 2-flop synchronizer
//                             ("type" is a reserved word in SystemVerilog)
//             step_count out  8-bit wrapping count of step pulses
//  Options  : `define STEP_INPUT_AUTO_STEP_EN to build the auto-repeat
//             counter (a further pulse every REPEAT_CYCLES while held).
//  Revision : 1.0  initial release
// ============================================================================
module step_input #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic       base_clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic [1:0] type_raw,
    output logic       step,
    output logic       btn_level,
    output logic [1:0] type_sync,
    output logic [7:0] step_count
);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_PRESS_CHK   = 2'd1;
    localparam logic [1:0] c_HELD        = 2'd2;
    localparam logic [1:0] c_RELEASE_CHK = 2'd3;

    localparam int c_MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                  DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity: counters must be able to hold the largest terminal
    // count, and both periods need at least two cycles.
    if ((CNT_W < $clog2(c_MAX_CYCLES)) || (DEBOUNCE_CYCLES < 2) ||
        (REPEAT_CYCLES < 2)) begin : g_param_check
        $error("step_input: illegal DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W");
    end

    logic             r_btn_meta;
    logic             r_btn_s;
    logic [1:0]       r_type_meta;
    logic [1:0]       r_type_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;
    logic             r_btn_level;
    logic [7:0]       r_step_count;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_step_nxt;

`ifdef STEP_INPUT_AUTO_STEP_EN
    localparam logic [CNT_W-1:0] c_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_nxt;
`endif

    // Next-state / next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
`ifdef STEP_INPUT_AUTO_STEP_EN
        w_rep_nxt   = r_rep_cnt;
`endif
        case (r_state)
            c_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = c_PRESS_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            c_PRESS_CHK: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_IDLE;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt = c_HELD;
                    w_step_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
`ifdef STEP_INPUT_AUTO_STEP_EN
                    w_rep_nxt   = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_RELEASE_CHK;
                    w_cnt_nxt   = '0;
                end
`ifdef STEP_INPUT_AUTO_STEP_EN
                else if (r_rep_cnt == c_REP_LAST) begin
                    w_step_nxt = 1'b1;
                    w_rep_nxt  = '0;
                end else begin
                    w_rep_nxt = r_rep_cnt + c_CNT_ONE;
                end
`endif
            end
            c_RELEASE_CHK: begin
                // A bounce back to 1 returns to HELD silently; the repeat
                // period restarts from zero on that re-entry.
                if (r_btn_s) begin
                    w_state_nxt = c_HELD;
`ifdef STEP_INPUT_AUTO_STEP_EN
                    w_rep_nxt   = '0;
`endif
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Synchronizers, state register and registered outputs.
    always_ff @(posedge base_clk) begin
        if (!reset) begin
            r_btn_meta   <= 1'b0;
            r_btn_s      <= 1'b0;
            r_type_meta  <= 2'b00;
            r_type_s     <= 2'b00;
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_step       <= 1'b0;
            r_btn_level  <= 1'b0;
            r_step_count <= 8'h00;
        end else begin
            r_btn_meta   <= btn_raw;
            r_btn_s      <= r_btn_meta;
            r_type_meta  <= type_raw;
            r_type_s     <= r_type_meta;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step       <= w_step_nxt;
            r_btn_level  <= (w_state_nxt == c_HELD) ||
                            (w_state_nxt == c_RELEASE_CHK);
            r_step_count <= r_step_count + {7'd0, r_step};
        end
    end

`ifdef STEP_INPUT_AUTO_STEP_EN
    always_ff @(posedge base_clk) begin
        if (!reset) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_nxt;
        end
    end
`endif

    assign step       = r_step;
    assign btn_level  = r_btn_level;
    assign type_sync  = r_type_s;
    assign step_count = r_step_count;

endmodule
`default_nettype wire
